timer_counter_ext: RTL and testbench

Parametrised successor to the 8-bit APB timer counter core. It counts rising edges of a PCLK-synchronous tick input (`clk_in`) over a configurable WIDTH, up or down, in three modes: free-run, auto-reload and one-shot. It adds a reload register, a compare-match event and sticky event flags with write-1-to-clear. It sits behind the APB register file, which drives its control inputs and reads back its count and flags.

---
 rtl/timer_counter_ext.sv | 112 +++++++++++
 tb/tb_timer_counter_ext.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter_ext.sv
// Tick-driven up/down timer with free-run, auto-reload and one-shot modes.
// Count and event pulses update one PCLK after a clk_in rise; flags follow a cycle later.
module timer_counter_ext #(
    parameter int WIDTH = 8
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             clk_in,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic [2:0]       flag_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic             cmp_pulse,
    output logic [2:0]       flags,
    output logic             running
);

    localparam logic [1:0]       MODE_RELOAD  = 2'b01;
    localparam logic [1:0]       MODE_ONESHOT = 2'b10;
    localparam logic [WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO     = '0;
    localparam logic [WIDTH-1:0] CNT_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             clk_in_q;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             cmp_q, cmp_d;
    logic [2:0]       flags_q, flags_d;
    logic             run;
    logic             tick;

    assign run  = en & ~done_q;
    assign tick = clk_in & ~clk_in_q & run;

    always_comb begin
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        done_d  = done_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        cmp_d   = 1'b0;
        // Pulse set wins over a same-cycle W1C clear.
        flags_d = (flags_q & ~flag_clr) | {cmp_q, unf_q, ovf_q};

        if (load) begin
            cnt_d  = load_val;
            rld_d  = load_val;
            done_d = 1'b0;
        end else if (tick) begin
            if (!dir && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (dir && cnt_q != CNT_ZERO) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                ovf_d = ~dir;
                unf_d = dir;
                case (mode)
                    MODE_RELOAD:  cnt_d = rld_q;
                    MODE_ONESHOT: begin
                        cnt_d  = rld_q;
                        done_d = 1'b1;
                    end
                    default:      cnt_d = dir ? CNT_MAX : CNT_ZERO;
                endcase
            end
            cmp_d = (cnt_d == cmp_val);
        end

        if (!en) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q    <= '0;
            rld_q    <= '0;
            clk_in_q <= 1'b1;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            cmp_q    <= 1'b0;
            flags_q  <= 3'b000;
        end else begin
            cnt_q    <= cnt_d;
            rld_q    <= rld_d;
            clk_in_q <= clk_in;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            cmp_q    <= cmp_d;
            flags_q  <= flags_d;
        end
    end

    assign cnt       = cnt_q;
    assign ovf_pulse = ovf_q;
    assign unf_pulse = unf_q;
    assign cmp_pulse = cmp_q;
    assign flags     = flags_q;
    assign running   = run;

endmodule

// File: tb/tb_timer_counter_ext.sv
// Directed bench for timer_counter_ext (WIDTH=8): vector table plus corner-case sequences.
module tb_timer_counter_ext;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       clk_in;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] cmp_val;
    logic [2:0] flag_clr;
    logic [7:0] cnt;
    logic       ovf_pulse;
    logic       unf_pulse;
    logic       cmp_pulse;
    logic [2:0] flags;
    logic       running;

    int n_chk  = 0;
    int n_fail = 0;

    timer_counter_ext #(.WIDTH(8)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .clk_in    (clk_in),
        .en        (en),
        .load      (load),
        .load_val  (load_val),
        .dir       (dir),
        .mode      (mode),
        .cmp_val   (cmp_val),
        .flag_clr  (flag_clr),
        .cnt       (cnt),
        .ovf_pulse (ovf_pulse),
        .unf_pulse (unf_pulse),
        .cmp_pulse (cmp_pulse),
        .flags     (flags),
        .running   (running)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       dr;
        logic [1:0] md;
        logic       ci;
        logic [2:0] fc;
        logic [7:0] e_cnt;
        logic       e_ovf;
        logic       e_unf;
        logic [2:0] e_flags;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ld, input logic [7:0] lv, input logic dr,
                       input logic [1:0] md, input logic ci, input logic [2:0] fc,
                       input logic [7:0] e_cnt, input logic e_ovf, input logic e_unf,
                       input logic [2:0] e_flags);
        vec_t v;
        v.ld = ld; v.lv = lv; v.dr = dr; v.md = md; v.ci = ci; v.fc = fc;
        v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_flags = e_flags;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_tick();
        clk_in = 1'b0;
        step();
        clk_in = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //   ld lv     dr md    ci fc      cnt    ovf  unf  flags
        add(1, 8'hFE, 0, 2'd0, 1, 3'b000, 8'hFE, 0, 0, 3'b000);
        add(0, 8'h00, 0, 2'd0, 0, 3'b000, 8'hFE, 0, 0, 3'b000);
        add(0, 8'h00, 0, 2'd0, 1, 3'b000, 8'hFF, 0, 0, 3'b000);
        add(0, 8'h00, 0, 2'd0, 0, 3'b000, 8'hFF, 0, 0, 3'b000);
        add(0, 8'h00, 0, 2'd0, 1, 3'b000, 8'h00, 1, 0, 3'b000);
        add(0, 8'h00, 0, 2'd0, 1, 3'b000, 8'h00, 0, 0, 3'b001);
        add(0, 8'h00, 0, 2'd0, 1, 3'b001, 8'h00, 0, 0, 3'b000);
        add(1, 8'h03, 1, 2'd1, 1, 3'b000, 8'h03, 0, 0, 3'b000);
        add(0, 8'h00, 1, 2'd1, 0, 3'b000, 8'h03, 0, 0, 3'b000);
        add(0, 8'h00, 1, 2'd1, 1, 3'b000, 8'h02, 0, 0, 3'b000);
        add(0, 8'h00, 1, 2'd1, 0, 3'b000, 8'h02, 0, 0, 3'b000);
        add(0, 8'h00, 1, 2'd1, 1, 3'b000, 8'h01, 0, 0, 3'b000);
        add(0, 8'h00, 1, 2'd1, 0, 3'b000, 8'h01, 0, 0, 3'b000);
        add(0, 8'h00, 1, 2'd1, 1, 3'b000, 8'h00, 0, 0, 3'b000);
        add(0, 8'h00, 1, 2'd1, 0, 3'b000, 8'h00, 0, 0, 3'b000);
        add(0, 8'h00, 1, 2'd1, 1, 3'b000, 8'h03, 0, 1, 3'b000);
        add(0, 8'h00, 1, 2'd1, 1, 3'b000, 8'h03, 0, 0, 3'b010);
        add(0, 8'h00, 1, 2'd1, 1, 3'b010, 8'h03, 0, 0, 3'b000);
        // load colliding with a tick at MAX: tick discarded
        add(1, 8'hFF, 0, 2'd0, 0, 3'b000, 8'hFF, 0, 0, 3'b000);
        add(1, 8'h20, 0, 2'd0, 1, 3'b000, 8'h20, 0, 0, 3'b000);
        add(0, 8'h00, 0, 2'd0, 1, 3'b000, 8'h20, 0, 0, 3'b000);
        // flag_clr colliding with a fresh ovf pulse: set wins
        add(1, 8'hFF, 0, 2'd0, 0, 3'b000, 8'hFF, 0, 0, 3'b000);
        add(0, 8'h00, 0, 2'd0, 1, 3'b000, 8'h00, 1, 0, 3'b000);
        add(0, 8'h00, 0, 2'd0, 1, 3'b000, 8'h00, 0, 0, 3'b001);
        add(1, 8'hFF, 0, 2'd0, 0, 3'b000, 8'hFF, 0, 0, 3'b001);
        add(0, 8'h00, 0, 2'd0, 1, 3'b000, 8'h00, 1, 0, 3'b001);
        add(0, 8'h00, 0, 2'd0, 1, 3'b001, 8'h00, 0, 0, 3'b001);
        add(0, 8'h00, 0, 2'd0, 1, 3'b001, 8'h00, 0, 0, 3'b000);

        PRESET = 1'b1; clk_in = 1'b1; en = 1'b1; load = 1'b0; load_val = 8'h00;
        dir = 1'b0; mode = 2'd0; cmp_val = 8'h80; flag_clr = 3'b000;
        step();
        step();
        chk("reset_cnt", cnt, 8'h00);
        chk("reset_flags", flags, 3'b000);
        chk("reset_pulses", {ovf_pulse, unf_pulse, cmp_pulse}, 3'b000);
        chk("reset_running", running, 1'b1);

        PRESET = 1'b0;
        step();
        step();
        chk("no_tick_after_reset", cnt, 8'h00);
        do_tick();
        chk("first_tick", cnt, 8'h01);

        for (int i = 0; i < vecs.size(); i++) begin
            load = vecs[i].ld; load_val = vecs[i].lv; dir = vecs[i].dr;
            mode = vecs[i].md; clk_in = vecs[i].ci; flag_clr = vecs[i].fc;
            step();
            chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].e_cnt);
            chk($sformatf("vec%0d_ovf", i), ovf_pulse, vecs[i].e_ovf);
            chk($sformatf("vec%0d_unf", i), unf_pulse, vecs[i].e_unf);
            chk($sformatf("vec%0d_cmp", i), cmp_pulse, 1'b0);
            chk($sformatf("vec%0d_flags", i), flags, vecs[i].e_flags);
            chk($sformatf("vec%0d_running", i), running, 1'b1);
        end
        load = 1'b0; flag_clr = 3'b000;

        // one-shot up
        mode = 2'd2; dir = 1'b0; load = 1'b1; load_val = 8'hFD;
        step();
        load = 1'b0;
        chk("os_load", cnt, 8'hFD);
        do_tick(); chk("os_t1", cnt, 8'hFE);
        do_tick(); chk("os_t2", cnt, 8'hFF);
        do_tick();
        chk("os_t3_cnt", cnt, 8'hFD);
        chk("os_t3_ovf", ovf_pulse, 1'b1);
        chk("os_t3_running", running, 1'b0);
        do_tick();
        chk("os_t4_cnt", cnt, 8'hFD);
        chk("os_t4_ovf", ovf_pulse, 1'b0);
        do_tick();
        chk("os_t5_cnt", cnt, 8'hFD);
        chk("os_t5_running", running, 1'b0);
        load = 1'b1; load_val = 8'hFE;
        step();
        load = 1'b0;
        chk("os_rearm_running", running, 1'b1);
        chk("os_rearm_cnt", cnt, 8'hFE);
        do_tick(); chk("os_rearm_tick", cnt, 8'hFF);

        // compare match
        mode = 2'd0; cmp_val = 8'h10; flag_clr = 3'b111;
        step();
        flag_clr = 3'b000;
        chk("cmp_clr_flags", flags, 3'b000);
        load = 1'b1; load_val = 8'h0E;
        step();
        load = 1'b0;
        do_tick();
        chk("cmp_t1_cnt", cnt, 8'h0F);
        chk("cmp_t1_pulse", cmp_pulse, 1'b0);
        do_tick();
        chk("cmp_t2_cnt", cnt, 8'h10);
        chk("cmp_t2_pulse", cmp_pulse, 1'b1);
        step();
        chk("cmp_pulse_one_cycle", cmp_pulse, 1'b0);
        chk("cmp_flag", flags, 3'b100);
        load = 1'b1; load_val = 8'h10;
        step();
        load = 1'b0;
        chk("cmp_load_no_pulse", cmp_pulse, 1'b0);
        chk("cmp_load_cnt", cnt, 8'h10);

        // mode 11 behaves as free-run: down from 0 wraps to MAX
        flag_clr = 3'b111;
        step();
        flag_clr = 3'b000;
        load = 1'b1; load_val = 8'h00; dir = 1'b1; mode = 2'd3;
        step();
        load = 1'b0;
        do_tick();
        chk("m3_cnt", cnt, 8'hFF);
        chk("m3_unf", unf_pulse, 1'b1);
        step();
        chk("m3_flags", flags, 3'b010);

        // en=0 holds count; re-enable with clk_in high gives no tick
        load = 1'b1; load_val = 8'h05; dir = 1'b0; mode = 2'd0; en = 1'b0;
        step();
        load = 1'b0;
        chk("dis_running", running, 1'b0);
        do_tick();
        chk("dis_hold", cnt, 8'h05);
        en = 1'b1;
        step();
        chk("reen_running", running, 1'b1);
        step();
        chk("reen_no_tick", cnt, 8'h05);

        // PRESET mid-count, coincident with a clk_in rise
        load = 1'b1; load_val = 8'h40;
        step();
        load = 1'b0;
        chk("pre_flags", flags, 3'b010);
        do_tick();
        chk("pre_cnt", cnt, 8'h41);
        clk_in = 1'b0;
        step();
        clk_in = 1'b1; PRESET = 1'b1;
        step();
        chk("mid_reset_cnt", cnt, 8'h00);
        chk("mid_reset_flags", flags, 3'b000);
        chk("mid_reset_pulses", {ovf_pulse, unf_pulse, cmp_pulse}, 3'b000);
        PRESET = 1'b0;
        step();
        chk("post_reset_no_tick", cnt, 8'h00);
        do_tick();
        chk("post_reset_tick", cnt, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
